demux_rr_sched: RTL
===================

Name: demux_rr_sched

Overview:
- Round-robin scheduler that distributes a single valid/ready word stream over three 16-bit consumer channels.
- Sequences the 1-to-3 demultiplexer datapath: picks the target channel, holds the word in a one-entry register, and drives the select code and per-channel handshakes.
- Unselected outputs read zero, and select code 2'b11 means "no output".
- Sits between a single producer and three downstream consumers.

Parameters:
- W, 16, data width of input and of each output channel.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  3  channel enable mask; bit0 = y1, bit1 = y2, bit2 = y3.
- x  in  W  input data word.
- x_valid  in  1  input word present.
- x_ready  out  1  block accepts x this cycle.
- y1, y2, y3  out  W  channel data; non-selected channels drive 0.
- y_valid  out  3  per-channel valid; one-hot or zero.
- y_ready  in  3  per-channel ready.
- s  out  2  current select code: 00 = y1, 01 = y2, 10 = y3, 11 = none.
- dcnt  out  CNT_W  number of words delivered since reset.

Behaviour:
- States:
  - IDLE: no word held.
  - HOLD: data_q is held for channel sel_q.
- Reset (async assert, sync release): state IDLE, data_q 0, sel_q 2'b11, ptr 2'b10, dcnt 0. All outputs read 0 during reset except s = 2'b11.
- Picker:
  - nxt = first channel with its en bit set, searched in order ptr+1, ptr+2, ptr+3 (mod 3, over channels 0..2).
  - ptr = last channel that completed a transfer.
  - After reset the first grant goes to y1.
- x_ready = (en != 0) && (state == IDLE || y_ready[sel_q]).
- Accept: x_valid && x_ready.
  - data_q <= x, sel_q <= nxt, state <= HOLD.
  - Output valid the next cycle; latency is 1 cycle.
- HOLD outputs:
  - y_valid[sel_q] = 1.
  - The selected yN = data_q; the other two = 0.
  - s = sel_q.
- Complete: y_ready[sel_q] in HOLD.
  - ptr <= sel_q, dcnt <= dcnt + 1; dcnt wraps at 2^CNT_W.
  - With a simultaneous accept, stay in HOLD and load the new word. nxt is computed from the updated ptr (= sel_q), so back-to-back words rotate. Full throughput is 1 word per cycle.
  - Without a simultaneous accept: state IDLE, sel_q <= 2'b11.
- IDLE outputs: y_valid = 0, y1/y2/y3 = 0, s = 2'b11.
- HOLD stalls while y_ready[sel_q] = 0. data_q and sel_q are stable and the valid does not drop. y_ready bits of non-selected channels are ignored.
- en changes:
  - Sampled only at accept time.
  - Clearing en[sel_q] during HOLD does not cancel the held word.
  - en == 0 forces x_ready = 0. A word already held still completes.
- Single enabled channel: every word goes to it; ptr stays there.
- x_valid without acceptance has no side effects. x is ignored when x_ready = 0.
- Reset mid-HOLD discards the held word; dcnt returns to 0.

Decomposition:
- Package demux_pkg:
  - constants SEL_Y1 = 2'b00, SEL_Y2 = 2'b01, SEL_Y3 = 2'b10, SEL_NONE = 2'b11;
  - typedef sel_t (logic [1:0]);
  - enum state_t {IDLE, HOLD};
  - default width W = 16.
- Sub-module rr_pick3: combinational. Inputs en[2:0] and ptr (sel_t); outputs nxt (sel_t) and any_en. Reused by later arbiters.
- The yN zero-forcing decode stays inline in demux_rr_sched.

Test Plan:
- Reset, en = 3'b111, y_ready = 3'b111, words 16'h0001..16'h0006 back-to-back → delivered to y1, y2, y3, y1, y2, y3 on consecutive cycles starting 1 cycle after the first accept; s follows 00, 01, 10, 00, 01, 10; dcnt = 6.
- en = 3'b101, four words → order y1, y3, y1, y3; y2 and y_valid[1] stay 0 throughout.
- Hold y_ready[0] = 0 for 5 cycles with word 16'hBEEF on y1 → y1 = 16'hBEEF and y_valid = 3'b001 stable for 5 cycles; x_ready = 0; the word completes on the cycle y_ready[0] = 1.
- en = 3'b000 with x_valid = 1 → x_ready = 0, s = 2'b11, all yN = 0, dcnt unchanged. Clear en during HOLD → the held word still completes.
- Assert rst_n = 0 mid-HOLD (word 16'hA5A5 on y2) → outputs go to 0 and s = 2'b11 immediately (asynchronously); after release the first word goes to y1 and dcnt restarts at 0.
- Preload dcnt near wrap (CNT_W = 4, 17 words) → dcnt reads 1 after the 17th transfer.

Source files
------------

// File: rtl/demux_rr_sched_pkg.sv
// demux_pkg: shared types and constants for the round-robin 1-to-3 demux
// scheduler and related arbiters.
//   sel_t      : 2-bit channel select code (00=y1, 01=y2, 10=y3, 11=none)
//   state_t    : IDLE (no word held) / HOLD (one word held for sel_q)
//   sel_inc    : next channel index modulo 3
//   sel_bit    : picks the bit of a 3-bit per-channel mask addressed by a select
package demux_pkg;

  localparam int unsigned DEF_W = 16;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_Y1   = 2'b00;
  localparam sel_t SEL_Y2   = 2'b01;
  localparam sel_t SEL_Y3   = 2'b10;
  localparam sel_t SEL_NONE = 2'b11;

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  // Channel rotation modulo 3; SEL_NONE wraps to y1.
  function automatic sel_t sel_inc(input sel_t p);
    case (p)
      SEL_Y1:  return SEL_Y2;
      SEL_Y2:  return SEL_Y3;
      default: return SEL_Y1;
    endcase
  endfunction

  // Per-channel mask lookup; SEL_NONE addresses no channel.
  function automatic logic sel_bit(input logic [2:0] m, input sel_t c);
    case (c)
      SEL_Y1:  return m[0];
      SEL_Y2:  return m[1];
      SEL_Y3:  return m[2];
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/demux_rr_sched_if.sv
// demux_rr_sched_if: producer/consumer bundle of the round-robin demux.
//   en       : channel enable mask (bit0=y1, bit1=y2, bit2=y3)
//   x/x_valid/x_ready : single input word stream
//   y1..y3   : channel data, y_valid/y_ready per-channel handshake
//   s        : current select code, dcnt : delivered-word counter
// modport slave is the demux side, master is the producer/consumer side.
interface demux_rr_sched_if
  import demux_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned CNT_W = 16
);

  logic [2:0]       en;
  logic [W-1:0]     x;
  logic             x_valid;
  logic             x_ready;
  logic [W-1:0]     y1;
  logic [W-1:0]     y2;
  logic [W-1:0]     y3;
  logic [2:0]       y_valid;
  logic [2:0]       y_ready;
  sel_t             s;
  logic [CNT_W-1:0] dcnt;

  modport slave (
    input  en, x, x_valid, y_ready,
    output x_ready, y1, y2, y3, y_valid, s, dcnt
  );

  modport master (
    output en, x, x_valid, y_ready,
    input  x_ready, y1, y2, y3, y_valid, s, dcnt
  );

endinterface

// File: rtl/demux_rr_sched_pick.sv
// rr_pick3: combinational 3-way round-robin picker.
//   en     (in)  : request/enable mask, bit N = channel N
//   ptr    (in)  : last served channel
//   nxt    (out) : first enabled channel in order ptr+1, ptr+2, ptr+3 (mod 3),
//                  SEL_NONE when nothing is enabled
//   any_en (out) : at least one channel enabled
module rr_pick3
  import demux_pkg::*;
(
  input  logic [2:0] en,
  input  sel_t       ptr,
  output sel_t       nxt,
  output logic       any_en
);

  sel_t w_c1;
  sel_t w_c2;
  sel_t w_c3;

  always_comb begin
    w_c1 = sel_inc(ptr);
    w_c2 = sel_inc(w_c1);
    w_c3 = sel_inc(w_c2);
    nxt  = SEL_NONE;
    if (sel_bit(en, w_c1)) begin
      nxt = w_c1;
    end else if (sel_bit(en, w_c2)) begin
      nxt = w_c2;
    end else if (sel_bit(en, w_c3)) begin
      nxt = w_c3;
    end
  end

  assign any_en = |en;

endmodule

// File: rtl/demux_rr_sched.sv
// demux_rr_sched: distributes one valid/ready word stream round-robin over
// three W-bit consumer channels through a one-entry holding register.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : demux_rr_sched_if.slave (en, x/x_valid/x_ready, y1..y3,
//           y_valid/y_ready, s, dcnt)
// Unselected channels read zero; s = 2'b11 while nothing is held.
module demux_rr_sched
  import demux_pkg::*;
#(
  parameter int unsigned W     = DEF_W,
  parameter int unsigned CNT_W = 16
)(
  input  logic              clk,
  input  logic              rst_n,
  demux_rr_sched_if.slave   bus
);

  state_t           r_state;
  logic [W-1:0]     r_data;
  sel_t             r_sel;
  sel_t             r_ptr;
  logic [CNT_W-1:0] r_dcnt;

  state_t           w_state_d;
  logic [W-1:0]     w_data_d;
  sel_t             w_sel_d;
  sel_t             w_ptr_d;
  logic [CNT_W-1:0] w_dcnt_d;

  logic             w_hold;
  logic             w_sel_rdy;
  logic             w_complete;
  logic             w_accept;
  logic             w_x_ready;
  logic             w_any_en;
  sel_t             w_pick_ptr;
  sel_t             w_nxt;

  assign w_hold     = (r_state == HOLD);
  assign w_sel_rdy  = sel_bit(bus.y_ready, r_sel);
  assign w_complete = w_hold && w_sel_rdy;
  // A word completing this cycle already counts as last served, so a word
  // accepted in the same cycle rotates onward from it.
  assign w_pick_ptr = w_complete ? r_sel : r_ptr;
  // rst_n gating keeps x_ready low while reset is asserted.
  assign w_x_ready  = rst_n && w_any_en && (!w_hold || w_sel_rdy);
  assign w_accept   = bus.x_valid && w_x_ready;

  rr_pick3 u_pick (
    .en     (bus.en),
    .ptr    (w_pick_ptr),
    .nxt    (w_nxt),
    .any_en (w_any_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_sel   <= SEL_NONE;
      r_ptr   <= SEL_Y3;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_d;
      r_data  <= w_data_d;
      r_sel   <= w_sel_d;
      r_ptr   <= w_ptr_d;
      r_dcnt  <= w_dcnt_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_data_d  = r_data;
    w_sel_d   = r_sel;
    w_ptr_d   = r_ptr;
    w_dcnt_d  = r_dcnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_data_d  = bus.x;
          w_sel_d   = w_nxt;
          w_state_d = HOLD;
        end
      end
      HOLD: begin
        if (w_complete) begin
          w_ptr_d  = r_sel;
          w_dcnt_d = r_dcnt + CNT_W'(1);
          if (w_accept) begin
            w_data_d = bus.x;
            w_sel_d  = w_nxt;
          end else begin
            w_state_d = IDLE;
            w_sel_d   = SEL_NONE;
          end
        end
      end
      default: begin
        w_state_d = IDLE;
        w_sel_d   = SEL_NONE;
      end
    endcase
  end

  always_comb begin
    bus.y_valid = '0;
    bus.y1      = '0;
    bus.y2      = '0;
    bus.y3      = '0;
    bus.s       = SEL_NONE;
    if (w_hold) begin
      bus.s = r_sel;
      case (r_sel)
        SEL_Y1: begin
          bus.y_valid = 3'b001;
          bus.y1      = r_data;
        end
        SEL_Y2: begin
          bus.y_valid = 3'b010;
          bus.y2      = r_data;
        end
        SEL_Y3: begin
          bus.y_valid = 3'b100;
          bus.y3      = r_data;
        end
        default: begin
          bus.y_valid = '0;
        end
      endcase
    end
  end

  assign bus.x_ready = w_x_ready;
  assign bus.dcnt    = r_dcnt;

endmodule
